// File: rtl/memory_arbiter_if.sv
// Bundle of the two requester ports and the memory-side port of the arbiter.
// slave: arbiter view. master: environment view (requesters plus memory adapter).
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Port 0: core controller
    logic                  m0_enable;
    logic                  m0_command;
    logic [ADDR_WIDTH-1:0] m0_address;
    logic [DATA_WIDTH-1:0] m0_write_data;
    logic [3:0]            m0_byte_enable;
    logic                  m0_ready;
    logic                  m0_valid;
    logic                  m0_error;
    logic [DATA_WIDTH-1:0] m0_read_data;

    // Port 1: DMA / debug master
    logic                  m1_enable;
    logic                  m1_command;
    logic [ADDR_WIDTH-1:0] m1_address;
    logic [DATA_WIDTH-1:0] m1_write_data;
    logic [3:0]            m1_byte_enable;
    logic                  m1_ready;
    logic                  m1_valid;
    logic                  m1_error;
    logic [DATA_WIDTH-1:0] m1_read_data;

    // Memory side
    logic                  memory_ready;
    logic                  memory_valid;
    logic [DATA_WIDTH-1:0] memory_read_data;
    logic                  memory_enable;
    logic                  memory_command;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic [DATA_WIDTH-1:0] memory_write_data;
    logic [3:0]            memory_byte_enable;

    modport slave (
        input  m0_enable, m0_command, m0_address, m0_write_data, m0_byte_enable,
        output m0_ready, m0_valid, m0_error, m0_read_data,
        input  m1_enable, m1_command, m1_address, m1_write_data, m1_byte_enable,
        output m1_ready, m1_valid, m1_error, m1_read_data,
        input  memory_ready, memory_valid, memory_read_data,
        output memory_enable, memory_command, memory_address, memory_write_data,
               memory_byte_enable
    );

    modport master (
        output m0_enable, m0_command, m0_address, m0_write_data, m0_byte_enable,
        input  m0_ready, m0_valid, m0_error, m0_read_data,
        output m1_enable, m1_command, m1_address, m1_write_data, m1_byte_enable,
        input  m1_ready, m1_valid, m1_error, m1_read_data,
        output memory_ready, memory_valid, memory_read_data,
        input  memory_enable, memory_command, memory_address, memory_write_data,
               memory_byte_enable
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single memory port.
// One transaction outstanding at a time; a watchdog answers with an error
// response when memory never completes, then swallows the late completion.
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memory_arbiter_if.slave       bus,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Timeout fires on the BUSY cycle whose increment would make the count
    // reach TIMEOUT_CYCLES, i.e. the TIMEOUT_CYCLES-th cycle after the grant.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    logic             turn;
    logic [CNT_W-1:0] cnt;

    logic offer;
    logic sel_enable;
    logic grant;
    logic timeout_hit;
    logic complete;

    // Ready depends only on state, turn and memory_ready (never on an enable),
    // so requesters may derive enable from ready without a loop. Reset gates it
    // so the ports are closed while reset_n is low.
    always_comb begin
        offer       = reset_n && (state == IDLE) && bus.memory_ready;
        sel_enable  = turn ? bus.m1_enable : bus.m0_enable;
        grant       = offer && sel_enable;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
        complete    = (state == BUSY) && (bus.memory_valid || timeout_hit);
    end

    assign bus.m0_ready = offer && !turn;
    assign bus.m1_ready = offer && turn;

    // Request fields follow the port that currently holds the turn.
    assign bus.memory_enable      = grant;
    assign bus.memory_command     = turn ? bus.m1_command     : bus.m0_command;
    assign bus.memory_address     = turn ? bus.m1_address     : bus.m0_address;
    assign bus.memory_write_data  = turn ? bus.m1_write_data  : bus.m0_write_data;
    assign bus.memory_byte_enable = turn ? bus.m1_byte_enable : bus.m0_byte_enable;

    // Completion passes straight through to the owner; a real completion in the
    // timeout cycle wins, so error is only raised without memory_valid.
    always_comb begin
        bus.m0_valid     = complete && !owner;
        bus.m1_valid     = complete && owner;
        bus.m0_error     = bus.m0_valid && !bus.memory_valid;
        bus.m1_error     = bus.m1_valid && !bus.memory_valid;
        bus.m0_read_data = (bus.m0_valid && bus.memory_valid) ? bus.memory_read_data : '0;
        bus.m1_read_data = (bus.m1_valid && bus.memory_valid) ? bus.memory_read_data : '0;
    end

    assign busy = (state != IDLE);

    // Arbitration FSM: poll/grant in IDLE, wait or time out in BUSY, and absorb
    // the one late completion in DRAIN before handing the turn over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            turn  <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= turn;
                        cnt   <= '0;
                        state <= BUSY;
                    end else if (bus.memory_ready) begin
                        turn <= ~turn;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus.memory_valid) begin
                        turn  <= ~owner;
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.memory_valid) begin
                        turn  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, single reads/writes, contention,
// watchdog timeout with drain, valid/timeout collision and reset mid-flight.
module tb_memory_arbiter;

    logic clk;
    logic reset_n;
    logic busy;
    logic owner;

    int n_assert = 0;
    int n_fail   = 0;

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n                = 1'b0;
        bus.m0_enable          = 1'b0;
        bus.m0_command         = 1'b0;
        bus.m0_address         = '0;
        bus.m0_write_data      = '0;
        bus.m0_byte_enable     = '0;
        bus.m1_enable          = 1'b0;
        bus.m1_command         = 1'b0;
        bus.m1_address         = '0;
        bus.m1_write_data      = '0;
        bus.m1_byte_enable     = '0;
        bus.memory_ready       = 1'b1;
        bus.memory_valid       = 1'b0;
        bus.memory_read_data   = '0;

        // In reset: everything closed even though memory is ready
        #2;
        chk("rst_m0_ready", bus.m0_ready, 0);
        chk("rst_m1_ready", bus.m1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mem_enable", bus.memory_enable, 0);
        chk("rst_m0_valid", bus.m0_valid, 0);

        cyc();
        cyc();
        reset_n = 1'b1;
        // Spurious completion in IDLE is ignored; port 0 holds the turn
        bus.memory_valid     = 1'b1;
        bus.memory_read_data = 32'h1111_2222;
        #1;
        chk("idle_m0_ready", bus.m0_ready, 1);
        chk("idle_m1_ready", bus.m1_ready, 0);
        chk("spur_m0_valid", bus.m0_valid, 0);
        chk("spur_m1_valid", bus.m1_valid, 0);
        chk("spur_busy", busy, 0);

        cyc();  // turn flipped to 1
        bus.memory_valid = 1'b0;
        bus.memory_ready = 1'b0;
        #1;
        chk("memnr_m1_ready", bus.m1_ready, 0);
        chk("memnr_m0_ready", bus.m0_ready, 0);
        cyc();  // turn held at 1
        bus.memory_ready = 1'b1;
        #1;
        chk("hold_m1_ready", bus.m1_ready, 1);
        chk("hold_m0_ready", bus.m0_ready, 0);
        cyc();  // turn back to 0

        // Port 0 read of 0x100, memory answers 3 cycles after grant
        bus.m0_enable  = 1'b1;
        bus.m0_command = 1'b0;
        bus.m0_address = 32'h0000_0100;
        #1;
        chk("rd_m0_ready", bus.m0_ready, 1);
        chk("rd_mem_enable", bus.memory_enable, 1);
        chk("rd_mem_addr", bus.memory_address, 32'h100);
        chk("rd_mem_cmd", bus.memory_command, 0);
        cyc();
        bus.m0_enable  = 1'b0;
        bus.m0_address = 32'hFFFF_FFFF;
        #1;
        chk("rd_busy", busy, 1);
        chk("rd_owner", owner, 0);
        chk("rd_busy_m0_ready", bus.m0_ready, 0);
        chk("rd_busy_mem_enable", bus.memory_enable, 0);
        chk("rd_wait1_valid", bus.m0_valid, 0);
        cyc();
        #1;
        chk("rd_wait2_valid", bus.m0_valid, 0);
        cyc();
        bus.memory_valid     = 1'b1;
        bus.memory_read_data = 32'hDEAD_BEEF;
        #1;
        chk("rd_m0_valid", bus.m0_valid, 1);
        chk("rd_m0_data", bus.m0_read_data, 32'hDEAD_BEEF);
        chk("rd_m0_error", bus.m0_error, 0);
        chk("rd_m1_valid", bus.m1_valid, 0);
        chk("rd_m1_data", bus.m1_read_data, 0);
        cyc();  // IDLE, turn = 1
        bus.memory_valid = 1'b0;
        #1;
        chk("rd_after_valid", bus.m0_valid, 0);
        chk("rd_after_data", bus.m0_read_data, 0);
        chk("rd_after_busy", busy, 0);
        chk("rd_after_m1_ready", bus.m1_ready, 1);
        cyc();  // no request: turn = 0

        // Port 1 write starting while turn is on port 0
        bus.m1_enable      = 1'b1;
        bus.m1_command     = 1'b1;
        bus.m1_address     = 32'h0000_0200;
        bus.m1_write_data  = 32'h1234_5678;
        bus.m1_byte_enable = 4'b0011;
        #1;
        chk("wr_wait_m1_ready", bus.m1_ready, 0);
        chk("wr_wait_mem_enable", bus.memory_enable, 0);
        cyc();
        #1;
        chk("wr_m1_ready", bus.m1_ready, 1);
        chk("wr_mem_enable", bus.memory_enable, 1);
        chk("wr_mem_addr", bus.memory_address, 32'h200);
        chk("wr_mem_cmd", bus.memory_command, 1);
        chk("wr_mem_wdata", bus.memory_write_data, 32'h1234_5678);
        chk("wr_mem_be", bus.memory_byte_enable, 4'b0011);
        cyc();
        bus.m1_enable        = 1'b0;
        bus.memory_valid     = 1'b1;
        bus.memory_read_data = 32'hAAAA_5555;
        #1;
        chk("wr_owner", owner, 1);
        chk("wr_m1_valid", bus.m1_valid, 1);
        chk("wr_m1_error", bus.m1_error, 0);
        chk("wr_m0_valid", bus.m0_valid, 0);
        cyc();  // IDLE, turn = 0

        // Contention: both ports request continuously, 1-cycle memory
        bus.m0_enable = 1'b1;
        bus.m1_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic p;
            p = (i % 2 == 1);
            bus.memory_valid = 1'b0;
            #1;
            chk("ct_mem_enable", bus.memory_enable, 1);
            chk("ct_ready_turn", p ? bus.m1_ready : bus.m0_ready, 1);
            chk("ct_ready_other", p ? bus.m0_ready : bus.m1_ready, 0);
            cyc();
            bus.memory_valid = 1'b1;
            #1;
            chk("ct_owner", owner, p);
            chk("ct_valid_owner", p ? bus.m1_valid : bus.m0_valid, 1);
            chk("ct_valid_other", p ? bus.m0_valid : bus.m1_valid, 0);
            cyc();
        end

        // Timeout: memory never answers port 0; late completion at cycle 30
        bus.m1_enable    = 1'b0;
        bus.m0_enable    = 1'b1;
        bus.memory_valid = 1'b0;
        #1;
        chk("to_grant", bus.memory_enable, 1);
        chk("to_m0_ready", bus.m0_ready, 1);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            bus.m0_enable        = 1'b0;
            bus.memory_read_data = 32'h5A5A_5A5A;
            bus.memory_valid     = (k == 30) || (k == 32);
            bus.m1_enable        = (k >= 17) && (k <= 31);
            #1;
            if (k < 16) begin
                chk("to_wait_valid", bus.m0_valid, 0);
                chk("to_wait_busy", busy, 1);
            end else if (k == 16) begin
                chk("to_m0_valid", bus.m0_valid, 1);
                chk("to_m0_error", bus.m0_error, 1);
                chk("to_m0_data", bus.m0_read_data, 0);
                chk("to_m1_valid", bus.m1_valid, 0);
            end else if (k < 30) begin
                chk("drain_busy", busy, 1);
                chk("drain_m1_ready", bus.m1_ready, 0);
                chk("drain_m0_valid", bus.m0_valid, 0);
            end else if (k == 30) begin
                chk("late_m0_valid", bus.m0_valid, 0);
                chk("late_m1_valid", bus.m1_valid, 0);
                chk("late_busy", busy, 1);
            end else if (k == 31) begin
                chk("post_busy", busy, 0);
                chk("post_m1_ready", bus.m1_ready, 1);
                chk("post_mem_enable", bus.memory_enable, 1);
            end else begin
                chk("post_owner", owner, 1);
                chk("post_m1_valid", bus.m1_valid, 1);
                chk("post_m1_error", bus.m1_error, 0);
                chk("post_m1_data", bus.m1_read_data, 32'h5A5A_5A5A);
            end
        end
        cyc();  // IDLE, turn = 0
        bus.m1_enable    = 1'b0;
        bus.memory_valid = 1'b0;

        // memory_valid lands in the timeout cycle
        bus.m0_enable = 1'b1;
        #1;
        chk("co_grant", bus.memory_enable, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            bus.m0_enable        = 1'b0;
            bus.memory_valid     = (k == 16);
            bus.memory_read_data = 32'hCAFE_F00D;
            #1;
            if (k == 16) begin
                chk("co_m0_valid", bus.m0_valid, 1);
                chk("co_m0_error", bus.m0_error, 0);
                chk("co_m0_data", bus.m0_read_data, 32'hCAFE_F00D);
            end
        end
        cyc();
        bus.memory_valid = 1'b0;
        #1;
        chk("co_idle_busy", busy, 0);
        chk("co_idle_m1_ready", bus.m1_ready, 1);

        // Reset in the middle of a port 1 transaction
        bus.m1_enable = 1'b1;
        #1;
        chk("mr_grant", bus.memory_enable, 1);
        cyc();
        bus.m1_enable = 1'b0;
        bus.m0_enable = 1'b1;
        #1;
        chk("mr_busy", busy, 1);
        chk("mr_owner", owner, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_rst_busy", busy, 0);
        chk("mr_rst_owner", owner, 0);
        chk("mr_rst_m0_ready", bus.m0_ready, 0);
        chk("mr_rst_m1_ready", bus.m1_ready, 0);
        chk("mr_rst_mem_enable", bus.memory_enable, 0);
        bus.memory_valid = 1'b1;
        #1;
        chk("mr_rst_m1_valid", bus.m1_valid, 0);
        cyc();
        reset_n       = 1'b1;
        bus.m0_enable = 1'b0;
        #1;
        chk("mr_late_m0_valid", bus.m0_valid, 0);
        chk("mr_late_m1_valid", bus.m1_valid, 0);
        chk("mr_late_busy", busy, 0);
        chk("mr_m0_ready", bus.m0_ready, 1);
        cyc();
        bus.memory_valid = 1'b0;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
